// File: rtl/fc_output_serializer_if.sv
// Stream bundle around the output serializer: a P-lane vector input stream
// and a single-word output stream, each with its own valid/ready pair.
interface fc_output_serializer_if #(
  parameter int T = 16,
  parameter int P = 4
);
  logic           vec_valid;
  logic           vec_ready;
  logic [P*T-1:0] vec_data;
  logic           output_valid;
  logic           output_ready;
  logic [T-1:0]   output_data;

  // Serializer side: sinks vectors, sources words
  modport slave (
    input  vec_valid, vec_data, output_ready,
    output vec_ready, output_valid, output_data
  );

  // Environment side: sources vectors, sinks words
  modport master (
    output vec_valid, vec_data, output_ready,
    input  vec_ready, output_valid, output_data
  );
endinterface

// File: rtl/fc_output_serializer.sv
// Output serializer for the fc_* layers. Takes one P-lane vector per
// handshake, optionally applies ReLU, and streams the lanes out one word per
// cycle. A frame counter trims the final vector of each N-word frame so the
// downstream sees exactly N words per frame.
module fc_output_serializer #(
  parameter int T = 16,
  parameter int P = 4,
  parameter int N = 16,
  parameter int R = 1
) (
  input logic                 clk,
  input logic                 reset,
  fc_output_serializer_if.slave bus
);

  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [P*T-1:0] hold_q, hold_d;
  logic           lastLane;
  logic           vecReady;

  // Zero every negative lane when ReLU is enabled; identity otherwise.
  function automatic logic [P*T-1:0] applyRelu(input logic [P*T-1:0] v);
    logic [P*T-1:0] r;
    r = v;
    if (R == 1) begin
      for (int k = 0; k < P; k++) begin
        if (v[k*T+T-1]) r[k*T +: T] = '0;
      end
    end
    return r;
  endfunction

  // A lane is the last of its vector either at the top lane or when it is
  // the final word of the frame; vectors always start frame-aligned, so the
  // second case trims the last vector to N mod P lanes.
  assign lastLane = (lane_q == LW'(P - 1)) || (frame_q == FW'(N - 1));

  // Next-state logic: vector capture, lane stepping, frame counting and the
  // combinational vec_ready that allows a bubble-free reload on the last lane.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    vecReady = 1'b0;
    case (state_q)
      IDLE: begin
        vecReady = !reset;
        if (bus.vec_valid) begin
          hold_d  = applyRelu(bus.vec_data);
          lane_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.output_ready) begin
          frame_d = (frame_q == FW'(N - 1)) ? '0 : frame_q + 1'b1;
          if (lastLane) begin
            vecReady = !reset;
            lane_d   = '0;
            if (bus.vec_valid) begin
              hold_d  = applyRelu(bus.vec_data);
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any vector still being emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      frame_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.vec_ready    = vecReady;
  assign bus.output_valid = (state_q == SEND);
  assign bus.output_data  = (state_q == SEND) ? hold_q[lane_q*T +: T] : '0;

endmodule

// File: tb/tb_fc_output_serializer.sv
// Bench for fc_output_serializer. Three instances cover ReLU on/off and a
// trimmed frame (N=6); a select drives one at a time. Expected words are
// queued when a vector is accepted and a monitor compares every presented word.
module tb_fc_output_serializer;
  localparam int T = 16;
  localparam int P = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           vecValid = 1'b0;
  logic           outReady = 1'b0;
  logic [P*T-1:0] vecData = '0;
  int             sel = 0;

  // Free-running clock
  initial forever #5 clk = ~clk;

  fc_output_serializer_if #(.T(T), .P(P)) ifA ();
  fc_output_serializer_if #(.T(T), .P(P)) ifB ();
  fc_output_serializer_if #(.T(T), .P(P)) ifC ();

  fc_output_serializer #(.T(T), .P(P), .N(16), .R(1)) dutA (.clk(clk), .reset(reset), .bus(ifA.slave));
  fc_output_serializer #(.T(T), .P(P), .N(16), .R(0)) dutB (.clk(clk), .reset(reset), .bus(ifB.slave));
  fc_output_serializer #(.T(T), .P(P), .N(6),  .R(0)) dutC (.clk(clk), .reset(reset), .bus(ifC.slave));

  assign ifA.vec_valid    = vecValid && (sel == 0);
  assign ifB.vec_valid    = vecValid && (sel == 1);
  assign ifC.vec_valid    = vecValid && (sel == 2);
  assign ifA.vec_data     = vecData;
  assign ifB.vec_data     = vecData;
  assign ifC.vec_data     = vecData;
  assign ifA.output_ready = outReady && (sel == 0);
  assign ifB.output_ready = outReady && (sel == 1);
  assign ifC.output_ready = outReady && (sel == 2);

  logic           muxVecReady, muxValid;
  logic [T-1:0]   muxData;

  // Route the selected instance's outputs to the checker
  always_comb begin
    case (sel)
      0:       begin muxVecReady = ifA.vec_ready; muxValid = ifA.output_valid; muxData = ifA.output_data; end
      1:       begin muxVecReady = ifB.vec_ready; muxValid = ifB.output_valid; muxData = ifB.output_data; end
      default: begin muxVecReady = ifC.vec_ready; muxValid = ifC.output_valid; muxData = ifC.output_data; end
    endcase
  end

  typedef struct {
    logic [T-1:0] data;
    bit           last;
  } exp_t;

  exp_t         expQ[$];
  int           vectorCount = 0;
  int           miscompares = 0;
  int           framePos[3] = '{0, 0, 0};
  bit           reluOf[3]   = '{1'b1, 1'b0, 1'b0};
  int           nOf[3]      = '{16, 16, 6};
  bit           monitorOn   = 1'b0;
  bit           checkBubbles = 1'b0;
  bit           randomReady = 1'b0;
  bit           stallPrev   = 1'b0;
  logic [T-1:0] stallData   = '0;

  task automatic checkOutput(input string name, input logic [T-1:0] actual, input logic [T-1:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNote(input string name, input string detail);
    vectorCount++;
    miscompares++;
    $display("[TB] FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  function automatic logic [P*T-1:0] pack4(input logic [T-1:0] a, input logic [T-1:0] b,
                                           input logic [T-1:0] c, input logic [T-1:0] d);
    return {d, c, b, a};
  endfunction

  // Reference model: queue the words an accepted vector should produce
  function automatic void pushExpected(input logic [P*T-1:0] vec);
    int   remaining;
    int   lanes;
    exp_t e;
    logic [T-1:0] w;
    remaining = nOf[sel] - framePos[sel];
    lanes = (remaining < P) ? remaining : P;
    for (int k = 0; k < lanes; k++) begin
      w = vec[k*T +: T];
      if (reluOf[sel] && w[T-1]) w = '0;
      e.data = w;
      e.last = (k == lanes - 1);
      expQ.push_back(e);
    end
    framePos[sel] = (framePos[sel] + lanes) % nOf[sel];
  endfunction

  task automatic applyStimulus(input logic [P*T-1:0] vec);
    bit accepted;
    bit hs;
    accepted = 1'b0;
    vecData  = vec;
    vecValid = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      hs = muxVecReady;
      @(posedge clk);
      if (hs) begin
        accepted = 1'b1;
        pushExpected(vec);
      end
      #1;
    end
    vecValid = 1'b0;
    if (!accepted) failNote("accept_timeout", "got no vector handshake, required one within 200 cycles");
  endtask

  task automatic drain(input int maxCycles);
    for (int c = 0; c < maxCycles && expQ.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (expQ.size() != 0) begin
      failNote("drain_timeout", $sformatf("got %0d words still pending, required 0", expQ.size()));
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    expQ.delete();
    framePos  = '{0, 0, 0};
    stallPrev = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented word against the queue head, check
  // vec_ready timing, stall stability and (when enabled) absence of bubbles.
  always @(negedge clk) begin
    if (monitorOn && !reset) begin
      if (muxValid) begin
        if (stallPrev) checkOutput("stall_data_hold", muxData, stallData);
        if (expQ.size() == 0) begin
          failNote("unexpected_word", $sformatf("got word 0x%h, required none", muxData));
        end else begin
          checkOutput("word", muxData, expQ[0].data);
          checkOutput("vec_ready_send", {15'b0, muxVecReady}, {15'b0, expQ[0].last && outReady});
          if (outReady) void'(expQ.pop_front());
        end
        stallPrev = !outReady;
        stallData = muxData;
      end else begin
        if (stallPrev) checkOutput("stall_valid_hold", {15'b0, muxValid}, 16'h0001);
        checkOutput("vec_ready_idle", {15'b0, muxVecReady}, 16'h0001);
        if (checkBubbles && expQ.size() != 0)
          failNote("bubble", "got output_valid=0, required 1 with words pending");
        stallPrev = 1'b0;
      end
    end
  end

  // Random downstream back-pressure, applied after the stimulus updates
  initial forever begin
    @(posedge clk);
    #2;
    if (randomReady) outReady = ($urandom_range(1, 0) == 1);
  end

  // Directed test sequence
  initial begin
    logic [T-1:0] w[4];

    // Reset state, with both inputs asserted to show vec_ready forced low
    vecValid = 1'b1;
    outReady = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_validA", {15'b0, ifA.output_valid}, 16'h0000);
    checkOutput("rst_dataA", ifA.output_data, 16'h0000);
    checkOutput("rst_vreadyA", {15'b0, ifA.vec_ready}, 16'h0000);
    checkOutput("rst_validC", {15'b0, ifC.output_valid}, 16'h0000);
    checkOutput("rst_vreadyC", {15'b0, ifC.vec_ready}, 16'h0000);
    vecValid = 1'b0;
    outReady = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_vreadyA", {15'b0, ifA.vec_ready}, 16'h0001);
    checkOutput("idle_vreadyB", {15'b0, ifB.vec_ready}, 16'h0001);
    checkOutput("idle_validB", {15'b0, ifB.output_valid}, 16'h0000);
    monitorOn = 1'b1;

    // ReLU lanes [5,-3,7,-1] -> 5,0,7,0 starting the cycle after acceptance
    $display("[TB] ReLU vector");
    sel = 0;
    outReady = 1'b1;
    checkBubbles = 1'b1;
    applyStimulus(pack4(16'h0005, 16'hFFFD, 16'h0007, 16'hFFFF));
    checkOutput("first_lane_valid", {15'b0, muxValid}, 16'h0001);
    checkOutput("first_lane_data", muxData, 16'h0005);
    drain(20);

    // Four back-to-back vectors 1,-2,3,-4,...,-16 with ReLU off
    $display("[TB] back-to-back frame");
    sel = 1;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 4; k++) begin
        w[k] = ((4*v + k) % 2 == 1) ? T'(-(4*v + k + 1)) : T'(4*v + k + 1);
      end
      applyStimulus(pack4(w[0], w[1], w[2], w[3]));
    end
    drain(30);

    // Trimmed frame N=6: [1,2,3,4],[5,6,99,99],[7,8,9,10]
    $display("[TB] trimmed frame");
    sel = 2;
    applyStimulus(pack4(16'd1, 16'd2, 16'd3, 16'd4));
    applyStimulus(pack4(16'd5, 16'd6, 16'd99, 16'd99));
    applyStimulus(pack4(16'd7, 16'd8, 16'd9, 16'd10));
    drain(30);

    // Reset during lane 1 of [10,20,30,40]
    $display("[TB] reset mid-send");
    resetDut();
    applyStimulus(pack4(16'd10, 16'd20, 16'd30, 16'd40));
    @(posedge clk);
    #1;
    checkOutput("lane1_before_reset", muxData, 16'd20);
    reset = 1'b1;
    outReady = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_valid", {15'b0, muxValid}, 16'h0000);
    checkOutput("reset_vready", {15'b0, muxVecReady}, 16'h0000);
    expQ.delete();
    framePos  = '{0, 0, 0};
    stallPrev = 1'b0;
    reset = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_valid", {15'b0, muxValid}, 16'h0000);
    applyStimulus(pack4(16'd1, 16'd2, 16'd3, 16'd4));
    applyStimulus(pack4(16'd5, 16'd6, 16'd99, 16'd99));
    drain(30);

    // 20-cycle stall with lane 0 = 0x1234, then release
    $display("[TB] long stall");
    sel = 1;
    outReady = 1'b0;
    applyStimulus(pack4(16'h1234, 16'h0002, 16'h8003, 16'h0004));
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_end_data", muxData, 16'h1234);
    checkOutput("stall_end_vready", {15'b0, muxVecReady}, 16'h0000);
    outReady = 1'b1;
    drain(20);

    // Random valid/ready traffic over 2500 vectors
    $display("[TB] random traffic");
    sel = 0;
    checkBubbles = 1'b0;
    randomReady = 1'b1;
    for (int v = 0; v < 2500; v++) begin
      while ($urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
      end
      applyStimulus({$urandom, $urandom});
    end
    randomReady = 1'b0;
    outReady = 1'b1;
    drain(100);

    monitorOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule

// File: doc/fc_output_serializer.md
Name: fc_output_serializer

Overview:
Transmit stage at the output end of the fc_* layers. It accepts one vector of P parallel T-bit layer results per handshake and applies the optional ReLU. It then emits the results one word at a time on the layer's output stream (output_valid/output_ready/output_data), which is what the layer benches consume. Its frame counter trims the last vector of each N-output frame when N is not a multiple of P.

Parameters:
T, 16, word width in bits (signed two's complement)
P, 4, lanes per input vector
N, 16, output words per frame (layer output count)
R, 1, 1 = apply ReLU (negative -> 0), 0 = pass through

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
vec_valid  input  1  vec_data holds a valid P-lane vector
vec_ready  output  1  block accepts the vector this cycle
vec_data  input  P*T  lane k at bits [k*T+T-1:k*T]; lane 0 emitted first
output_valid  output  1  output_data holds a valid word
output_ready  input  1  downstream accepts the word this cycle
output_data  output  T  signed result word

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: output_valid=0, output_data=0, lane counter=0, frame counter=0, state=IDLE. vec_ready is forced 0 while reset=1. Any in-flight vector is discarded, and remaining lanes are never emitted.
- Handshakes: a transfer occurs on a rising edge where valid&&ready=1. While output_valid=1 and output_ready=0, output_data and output_valid hold unchanged. output_valid never drops without a completed transfer, except on reset.
- States:
  - IDLE: output_valid=0, vec_ready=1. On a vec handshake, capture vec_data into the hold register (ReLU applied per lane if R=1) and move to SEND with lane=0.
  - SEND: output_valid=1, output_data=hold lane[lane]. On an output handshake, lane increments.
- Lanes per vector: L = P normally. For the final vector of a frame, L = N-(frame words sent so far) = N mod P, when that is nonzero.
- Last-lane handshake (lane==L-1):
  - vec_ready=1 in that same cycle (combinational: state==SEND && lane==L-1 && output_ready).
  - If vec_valid is also 1, the new vector is loaded and SEND continues with lane=0, so there is no bubble.
  - Otherwise the block returns to IDLE.
- vec_ready=0 in SEND on every other lane.
- Latency: a vector accepted at edge k gives lane 0 on output_valid after edge k (visible in cycle k+1). Sustained throughput is 1 word/cycle.
- Frame counter: counts words emitted, 0..N-1, and wraps to 0 after word N-1. Unused upper lanes of a trimmed final vector are dropped silently.
- ReLU: a word with MSB=1 becomes 0 when R=1. No saturation; words are not rescaled (width T in, T out).
- Boundary cases:
  - vec_valid asserted while busy on a non-last lane: not accepted; the upstream holds.
  - output_ready=1 in IDLE: no effect.
  - P=1: every word is a last lane and the block degenerates to a registered pipe stage.
  - N<P: every vector is trimmed to N lanes.
  - Reset asserted mid-SEND: the block is IDLE, with output_valid=0, on the next cycle.

Test Plan:
1. R=1, P=4, N=16, output_ready=1; send vector lanes [5,-3,7,-1] -> outputs 0x0005,0x0000,0x0007,0x0000 in 4 consecutive cycles starting the cycle after acceptance.
2. R=0; send 4 back-to-back vectors (16 words, values 1..16 with alternate ones negated), output_ready=1, vec_valid=1 -> 16 words in 16 consecutive cycles, negatives preserved, vec_ready high exactly on each last lane, frame counter wraps to 0.
3. Random output_ready and vec_valid (50% each) over 2500 vectors, checked against a software reference model -> 10000 words correct and in order, output_data stable in every stalled cycle, zero errors.
4. N=6, P=4, R=0; send [1,2,3,4] then [5,6,99,99] then [7,8,9,10] -> outputs 1,2,3,4,5,6 (99s dropped), then 7,8,9,10 start the next frame.
5. Reset asserted during lane 1 of [10,20,30,40] -> output_valid=0 the cycle after reset, 30 and 40 are never emitted, and a fresh vector afterwards emits from lane 0 with frame counter 0.
6. output_ready=0 held for 20 cycles with lane 0=0x1234 presented -> output_valid=1 and output_data=0x1234 stable throughout, vec_ready=0; release -> remaining lanes follow on consecutive cycles.
